// File: rtl/vga_timing.sv
// ----------------------------------------------------------------------------
// vga_timing -- free-running VGA raster generator with a one-cycle pixel fetch.
//
// Stage 0 is the raw h/v counter pair. The counters are exported as pix_x and
// pix_y together with pix_req, which asks the framebuffer for the colour of
// that pixel. Stage 1 is the registered VGA output. It aligns colour, syncs and
// blank so that all of them trail the counters by exactly one cycle.
//
// Ports
//   CLOCK_25          in   1   pixel clock; every register uses its rising edge
//   rst               in   1   synchronous, active-high reset
//   pix_x, pix_y      out  10  current column / line (stage 0)
//   pix_req           out  1   (pix_x,pix_y) is visible; pix_data is consumed
//   pix_data          in   24  {R,G,B} for the pixel requested by pix_req
//   frame_start       out  1   pulse at h=0, v=0
//   line_start        out  1   pulse at h=0 of every line
//   VGA_R/G/B         out  8   registered colour, zero while blanked (stage 1)
//   VGA_HS, VGA_VS    out  1   active-low syncs (stage 1)
//   VGA_BLANK_N       out  1   high during visible pixels (stage 1)
//
// The geometry parameters must keep the total counts (HT, VT) at or below
// 1024, so that the 10-bit counters can hold them.
// ----------------------------------------------------------------------------
module vga_timing #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic        CLOCK_25,
    input  logic        rst,
    output logic [9:0]  pix_x,
    output logic [9:0]  pix_y,
    output logic        pix_req,
    input  logic [23:0] pix_data,
    output logic        frame_start,
    output logic        line_start,
    output logic [7:0]  VGA_R,
    output logic [7:0]  VGA_G,
    output logic [7:0]  VGA_B,
    output logic        VGA_HS,
    output logic        VGA_VS,
    output logic        VGA_BLANK_N
);

    localparam int HT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int VT = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Thresholds pre-sized to the counter width so every compare is 10 vs 10 bits.
    localparam logic [9:0] H_LAST     = 10'(HT - 1);
    localparam logic [9:0] V_LAST     = 10'(VT - 1);
    localparam logic [9:0] H_VIS      = 10'(H_ACTIVE);
    localparam logic [9:0] V_VIS      = 10'(V_ACTIVE);
    localparam logic [9:0] HS_BEGIN   = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END     = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_BEGIN   = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END     = 10'(V_ACTIVE + V_FP + V_SYNC);

    logic [9:0] h;
    logic [9:0] v;
    logic       visible;
    logic       hsync_n;
    logic       vsync_n;

    // ------------------------------------------------------------------
    // Stage 0: raster counters. v advances only on the last pixel of a
    // line, so both counters wrap on the same edge at the end of a frame.
    // ------------------------------------------------------------------
    // NOTE: state is updated with non-blocking assignments only, so every
    // register samples the pre-edge values and ordering inside the block is irrelevant.
    always_ff @(posedge CLOCK_25) begin
        if (rst) begin
            h <= '0;
            v <= '0;
        end else if (h == H_LAST) begin
            h <= '0;
            v <= (v == V_LAST) ? 10'd0 : v + 10'd1;
        end else begin
            h <= h + 10'd1;
        end
    end

    // ------------------------------------------------------------------
    // Stage 0 decode. The strobes are gated by rst, so a consumer never
    // sees a request or a frame marker while the counters are held.
    // ------------------------------------------------------------------
    // NOTE: every signal in always_comb gets a value on every path; a
    // missing default would infer a latch.
    always_comb begin
        visible     = (h < H_VIS) && (v < V_VIS);
        hsync_n     = !((h >= HS_BEGIN) && (h < HS_END));
        vsync_n     = !((v >= VS_BEGIN) && (v < VS_END));
        pix_req     = !rst && visible;
        frame_start = !rst && (h == 10'd0) && (v == 10'd0);
        line_start  = !rst && (h == 10'd0);
    end

    assign pix_x = h;
    assign pix_y = v;

    // ------------------------------------------------------------------
    // Stage 1: the colour, the syncs and the blank are registered together.
    // pix_data is taken on the edge that ends the request cycle, and it is
    // replaced by black whenever no request was made. The sync path never
    // looks at pix_data, so the raster cannot stall.
    // ------------------------------------------------------------------
    always_ff @(posedge CLOCK_25) begin
        if (rst) begin
            VGA_HS      <= 1'b1;
            VGA_VS      <= 1'b1;
            VGA_BLANK_N <= 1'b0;
            VGA_R       <= '0;
            VGA_G       <= '0;
            VGA_B       <= '0;
        end else begin
            VGA_HS      <= hsync_n;
            VGA_VS      <= vsync_n;
            VGA_BLANK_N <= pix_req;
            if (pix_req) begin
                {VGA_R, VGA_G, VGA_B} <= pix_data;
            end else begin
                {VGA_R, VGA_G, VGA_B} <= 24'd0;
            end
        end
    end

endmodule

// File: tb/tb_vga_timing.sv
// ----------------------------------------------------------------------------
// tb_vga_timing -- directed self-checking bench for vga_timing.
//
// Two instances run side by side on one clock:
//   dut   -- default 640x480 geometry; reset release, line timing, blanking.
//   dut_s -- reduced geometry (32 x 20 total). A full frame, the frame wrap
//            and a mid-frame reset therefore fit in a short run.
// Reduced geometry: H 16/4/6/6 (HT=32, hsync low h=20..25),
//                   V 12/2/3/3 (VT=20, vsync low v=14..16), frame = 640 cycles.
// Outputs are sampled 1 time unit after the rising edge.
// ----------------------------------------------------------------------------
module tb_vga_timing;

    logic        clk = 1'b0;
    logic        rst;
    logic [23:0] pix_data;

    // default-geometry instance
    logic [9:0]  d_pix_x, d_pix_y;
    logic        d_pix_req, d_frame_start, d_line_start;
    logic [7:0]  d_r, d_g, d_b;
    logic        d_hs, d_vs, d_blank_n;

    // reduced-geometry instance
    logic [9:0]  s_pix_x, s_pix_y;
    logic        s_pix_req, s_frame_start, s_line_start;
    logic [7:0]  s_r, s_g, s_b;
    logic        s_hs, s_vs, s_blank_n;

    int n_tests = 0;
    int n_fail  = 0;

    always #20 clk = ~clk;

    vga_timing dut (
        .CLOCK_25    (clk),
        .rst         (rst),
        .pix_x       (d_pix_x),
        .pix_y       (d_pix_y),
        .pix_req     (d_pix_req),
        .pix_data    (pix_data),
        .frame_start (d_frame_start),
        .line_start  (d_line_start),
        .VGA_R       (d_r),
        .VGA_G       (d_g),
        .VGA_B       (d_b),
        .VGA_HS      (d_hs),
        .VGA_VS      (d_vs),
        .VGA_BLANK_N (d_blank_n)
    );

    vga_timing #(
        .H_ACTIVE (16), .H_FP (4), .H_SYNC (6), .H_BP (6),
        .V_ACTIVE (12), .V_FP (2), .V_SYNC (3), .V_BP (3)
    ) dut_s (
        .CLOCK_25    (clk),
        .rst         (rst),
        .pix_x       (s_pix_x),
        .pix_y       (s_pix_y),
        .pix_req     (s_pix_req),
        .pix_data    (pix_data),
        .frame_start (s_frame_start),
        .line_start  (s_line_start),
        .VGA_R       (s_r),
        .VGA_G       (s_g),
        .VGA_B       (s_b),
        .VGA_HS      (s_hs),
        .VGA_VS      (s_vs),
        .VGA_BLANK_N (s_blank_n)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int req_cnt, hs_low, hs_first, extra_ls, blank_bad;
        int f0, f1, vs_low, vs_first, blank_hi, hs_low_s, max_y, wraps, rgb_bad;
        logic [9:0] prev_x, prev_y;
        logic       found;

        rst      = 1'b1;
        pix_data = 24'hFFFFFF;

        // ---------------- reset state ----------------
        repeat (3) tick();
        check("rst_hs",          32'(d_hs),          32'd1);
        check("rst_vs",          32'(d_vs),          32'd1);
        check("rst_blank_n",     32'(d_blank_n),     32'd0);
        check("rst_rgb",         32'({d_r, d_g, d_b}), 32'h0);
        check("rst_pix_req",     32'(d_pix_req),     32'd0);
        check("rst_frame_start", 32'(d_frame_start), 32'd0);
        check("rst_line_start",  32'(d_line_start),  32'd0);
        check("rst_pix_x",       32'(d_pix_x),       32'd0);
        check("rst_pix_y",       32'(d_pix_y),       32'd0);

        // ---------------- release: first cycle at (0,0) ----------------
        rst      = 1'b0;
        pix_data = 24'h123456;
        #1;
        check("rel_frame_start", 32'(d_frame_start), 32'd1);
        check("rel_line_start",  32'(d_line_start),  32'd1);
        check("rel_pix_x",       32'(d_pix_x),       32'd0);
        check("rel_pix_y",       32'(d_pix_y),       32'd0);
        check("rel_pix_req",     32'(d_pix_req),     32'd1);
        check("rel_s_frame",     32'(s_frame_start), 32'd1);

        // ---------------- one full default line (t = cycles since line_start) ----
        req_cnt = 0; hs_low = 0; hs_first = -1; extra_ls = 0; blank_bad = 0;
        for (int t = 0; t <= 800; t++) begin
            if (t < 800 && d_pix_req) req_cnt++;
            if (t < 800 && !d_hs) begin
                hs_low++;
                if (hs_first < 0) hs_first = t;
            end
            if (t > 0 && t < 800 && d_line_start) extra_ls++;
            if (!d_blank_n && ({d_r, d_g, d_b} != 24'h0)) blank_bad++;

            if (t == 1) begin
                check("s1_blank_n",  32'(d_blank_n),          32'd1);
                check("s1_rgb",      32'({d_r, d_g, d_b}),    32'h123456);
                check("s1_pix_x",    32'(d_pix_x),            32'd1);
                check("s1_frame_lo", 32'(d_frame_start),      32'd0);
            end
            if (t == 2)   check("s1_rgb_next", 32'({d_r, d_g, d_b}), 32'hABCDEF);
            if (t == 640) begin
                check("blank_n_last_vis", 32'(d_blank_n),        32'd1);
                check("rgb_last_vis",     32'({d_r, d_g, d_b}),  32'hFFFFFF);
            end
            if (t == 641) begin
                check("blank_n_h640", 32'(d_blank_n),        32'd0);
                check("rgb_h640",     32'({d_r, d_g, d_b}),  32'h0);
            end
            if (t == 800) begin
                check("line2_line_start", 32'(d_line_start),  32'd1);
                check("line2_frame_lo",   32'(d_frame_start), 32'd0);
                check("line2_pix_x",      32'(d_pix_x),       32'd0);
                check("line2_pix_y",      32'(d_pix_y),       32'd1);
            end

            if (t == 1) pix_data = 24'hABCDEF;
            if (t == 2) pix_data = 24'hFFFFFF;
            if (t < 800) tick();
        end
        check("line_pix_req_cnt", 32'(req_cnt),   32'd640);
        check("line_hs_low_cnt",  32'(hs_low),    32'd96);
        check("line_hs_first",    32'(hs_first),  32'd657);
        check("line_extra_ls",    32'(extra_ls),  32'd0);
        check("line_blank_rgb",   32'(blank_bad), 32'd0);

        // ---------------- reduced-geometry frame timing and wrap ----------------
        f0 = -1; f1 = -1; vs_low = 0; vs_first = -1; blank_hi = 0; hs_low_s = 0;
        max_y = 0; wraps = 0; rgb_bad = 0;
        prev_x = s_pix_x; prev_y = s_pix_y;
        for (int c = 0; c < 1400; c++) begin
            tick();
            if (s_frame_start) begin
                if (f0 < 0) f0 = c;
                else if (f1 < 0) f1 = c;
            end
            if (f0 >= 0 && f1 < 0) begin
                if (!s_vs) begin
                    vs_low++;
                    if (vs_first < 0) vs_first = c - f0;
                end
                if (s_blank_n) blank_hi++;
                if (!s_hs) hs_low_s++;
            end
            if (32'(s_pix_y) > 32'(max_y)) max_y = 32'(s_pix_y);
            if (!s_blank_n && ({s_r, s_g, s_b} != 24'h0)) rgb_bad++;
            if (s_blank_n && ({s_r, s_g, s_b} != 24'hFFFFFF)) rgb_bad++;
            if (prev_x == 10'd31 && prev_y == 10'd19 && wraps == 0) begin
                wraps++;
                check("wrap_pix_x",       32'(s_pix_x),       32'd0);
                check("wrap_pix_y",       32'(s_pix_y),       32'd0);
                check("wrap_frame_start", 32'(s_frame_start), 32'd1);
                check("wrap_line_start",  32'(s_line_start),  32'd1);
            end
            prev_x = s_pix_x; prev_y = s_pix_y;
        end
        check("frame_period",   32'(f1 - f0),  32'd640);
        check("frame_vs_low",   32'(vs_low),   32'd96);
        check("frame_vs_first", 32'(vs_first), 32'd449);
        check("frame_blank_hi", 32'(blank_hi), 32'd192);
        check("frame_hs_low",   32'(hs_low_s), 32'd120);
        check("frame_max_y",    32'(max_y),    32'd19);
        check("frame_wrap_seen", 32'(wraps),   32'd1);
        check("frame_blank_rgb", 32'(rgb_bad), 32'd0);

        // ---------------- mid-frame reset (reduced: h=22, v=15, both syncs low) ----
        found = 1'b0;
        for (int i = 0; i < 700 && !found; i++) begin
            if (s_pix_x == 10'd22 && s_pix_y == 10'd15) found = 1'b1;
            else tick();
        end
        check("mid_reached", 32'(found), 32'd1);
        check("mid_pre_hs", 32'(s_hs), 32'd0);
        rst = 1'b1;
        #1;
        check("mid_req_gated", 32'(d_pix_req), 32'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("mid_hs",      32'(s_hs),                 32'd1);
            check("mid_vs",      32'(s_vs),                 32'd1);
            check("mid_blank_n", 32'(s_blank_n),            32'd0);
            check("mid_rgb",     32'({s_r, s_g, s_b}),      32'h0);
            check("mid_d_rgb",   32'({d_r, d_g, d_b}),      32'h0);
            check("mid_ls_gate", 32'(d_line_start),         32'd0);
            check("mid_fs_gate", 32'(s_frame_start),        32'd0);
        end
        rst = 1'b0;
        #1;
        check("restart_s_x",     32'(s_pix_x),       32'd0);
        check("restart_s_y",     32'(s_pix_y),       32'd0);
        check("restart_s_frame", 32'(s_frame_start), 32'd1);
        check("restart_s_req",   32'(s_pix_req),     32'd1);
        check("restart_d_frame", 32'(d_frame_start), 32'd1);
        check("restart_d_req",   32'(d_pix_req),     32'd1);
        tick();
        check("restart_s_x1",    32'(s_pix_x),            32'd1);
        check("restart_s_blank", 32'(s_blank_n),          32'd1);
        check("restart_s_rgb",   32'({s_r, s_g, s_b}),    32'hFFFFFF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
